// File: rtl/door_if.sv
// Door controller handshake bundle.
// master: main elevator FSM / cabin side (drives requests, buttons, sensors, timer expiry).
// slave : door_controller (drives motor, dwell-timer request and status back).
//   open_req, car_moving, open_btn, close_btn, obstruct, timer_T : master -> slave
//   door_open, motor_open, motor_close, nudge, door_closed, door_done : slave -> master
interface door_if;
    logic open_req;
    logic car_moving;
    logic open_btn;
    logic close_btn;
    logic obstruct;
    logic timer_T;
    logic door_open;
    logic motor_open;
    logic motor_close;
    logic nudge;
    logic door_closed;
    logic door_done;

    modport master (
        output open_req, car_moving, open_btn, close_btn, obstruct, timer_T,
        input  door_open, motor_open, motor_close, nudge, door_closed, door_done
    );

    modport slave (
        input  open_req, car_moving, open_btn, close_btn, obstruct, timer_T,
        output door_open, motor_open, motor_close, nudge, door_closed, door_done
    );
endinterface

// File: rtl/door_controller.sv
// Car-door sequencing FSM: open on request, hold open against the dwell timer, close with
// reopen-on-obstruction and a forced slow "nudge" close once reversals are exhausted.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - door_if.slave: requests/buttons/sensors/timer in, motor/status/timer request out
// All outputs are registered and decoded from the next state.
module door_controller #(
    parameter int unsigned MOVE_CYCLES = 50,
    parameter int unsigned MAX_REOPEN  = 3
) (
    input logic   clk,
    input logic   reset,
    door_if.slave bus
);

    localparam int unsigned MW = $clog2(2 * MOVE_CYCLES);
    localparam int unsigned RW = (MAX_REOPEN > 0) ? $clog2(MAX_REOPEN + 1) : 1;
    localparam logic [MW-1:0] MoveLast  = MW'(MOVE_CYCLES - 1);
    localparam logic [MW-1:0] NudgeLast = MW'(2 * MOVE_CYCLES - 1);

    typedef enum logic [2:0] {
        StClosed  = 3'd0,
        StOpening = 3'd1,
        StOpen    = 3'd2,
        StClosing = 3'd3,
        StNudge   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   move_cnt_q, move_cnt_d;
    logic [RW-1:0]   reopen_cnt_q, reopen_cnt_d;

    logic door_open_q, door_open_d;
    logic motor_open_q, motor_open_d;
    logic motor_close_q, motor_close_d;
    logic nudge_q, nudge_d;
    logic door_closed_q, door_closed_d;
    logic door_done_q, door_done_d;

    logic reopen_ok;
    assign reopen_ok = 32'(reopen_cnt_q) < MAX_REOPEN;

    always_comb begin
        state_d      = state_q;
        move_cnt_d   = move_cnt_q;
        reopen_cnt_d = reopen_cnt_q;

        case (state_q)
            StClosed: begin
                // Requests while the car moves are dropped, not queued.
                if ((bus.open_req || bus.open_btn) && !bus.car_moving) begin
                    state_d      = StOpening;
                    move_cnt_d   = '0;
                    reopen_cnt_d = '0;
                end
            end
            StOpening: begin
                if (move_cnt_q == MoveLast) begin
                    state_d    = StOpen;
                    move_cnt_d = '0;
                end else begin
                    move_cnt_d = move_cnt_q + MW'(1);
                end
            end
            StOpen: begin
                // open_btn outranks timer expiry and close_btn.
                if (bus.open_btn) begin
                    state_d = StOpen;
                end else if (bus.timer_T || bus.close_btn) begin
                    state_d    = StClosing;
                    move_cnt_d = '0;
                end
            end
            StClosing: begin
                if (bus.obstruct || bus.open_btn) begin
                    move_cnt_d = '0;
                    if (reopen_ok) begin
                        reopen_cnt_d = reopen_cnt_q + RW'(1);
                        state_d      = StOpening;
                    end else begin
                        state_d = StNudge;
                    end
                end else if (move_cnt_q == MoveLast) begin
                    state_d    = StClosed;
                    move_cnt_d = '0;
                end else begin
                    move_cnt_d = move_cnt_q + MW'(1);
                end
            end
            StNudge: begin
                if (move_cnt_q == NudgeLast) begin
                    state_d    = StClosed;
                    move_cnt_d = '0;
                end else begin
                    move_cnt_d = move_cnt_q + MW'(1);
                end
            end
            default: begin
                state_d      = StClosed;
                move_cnt_d   = '0;
                reopen_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        // Dropping door_open for one cycle restarts the dwell timer.
        door_open_d   = (state_d == StOpen) && !((state_q == StOpen) && bus.open_btn);
        motor_open_d  = (state_d == StOpening);
        motor_close_d = (state_d == StClosing) || (state_d == StNudge);
        nudge_d       = (state_d == StNudge);
        door_closed_d = (state_d == StClosed);
        door_done_d   = (state_d == StClosed) &&
                        ((state_q == StClosing) || (state_q == StNudge));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StClosed;
            move_cnt_q    <= '0;
            reopen_cnt_q  <= '0;
            door_open_q   <= 1'b0;
            motor_open_q  <= 1'b0;
            motor_close_q <= 1'b0;
            nudge_q       <= 1'b0;
            door_closed_q <= 1'b1;
            door_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            move_cnt_q    <= move_cnt_d;
            reopen_cnt_q  <= reopen_cnt_d;
            door_open_q   <= door_open_d;
            motor_open_q  <= motor_open_d;
            motor_close_q <= motor_close_d;
            nudge_q       <= nudge_d;
            door_closed_q <= door_closed_d;
            door_done_q   <= door_done_d;
        end
    end

    assign bus.door_open   = door_open_q;
    assign bus.motor_open  = motor_open_q;
    assign bus.motor_close = motor_close_q;
    assign bus.nudge       = nudge_q;
    assign bus.door_closed = door_closed_q;
    assign bus.door_done   = door_done_q;

endmodule

// File: doc/door_controller.md
Name: door_controller

Overview:
- Car-door sequencing FSM. Opens the door on request from the main elevator FSM, holds it open, and closes it again with reopen-on-obstruction and forced slow-close ("nudge") protection.
- Drives `door_open` to the door dwell timer and consumes that timer's expiry pulse `timer_T`; it is the requesting end of the timer interface.
- Reports door-closed status and a completion pulse back to the main FSM.

Parameters:
- MOVE_CYCLES, 50: cycles for a full open or close stroke at normal speed. Legal range is 2 or more.
- MAX_REOPEN, 3: number of obstruction/open-button reversals allowed per door cycle before the nudge close. Legal range is 0 or more.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- open_req  in  1  1-cycle pulse from the main FSM: car has stopped, open the door
- car_moving  in  1  car in motion; blocks opening
- open_btn  in  1  cabin door-open button, level
- close_btn  in  1  cabin door-close button, level
- obstruct  in  1  door-edge obstruction sensor, level
- timer_T  in  1  dwell-timer expiry pulse
- door_open  out  1  to the dwell timer; high = door held open, timer counting
- motor_open  out  1  open-direction motor drive
- motor_close  out  1  close-direction motor drive
- nudge  out  1  slow forced close in progress (buzzer/indicator)
- door_closed  out  1  door fully closed
- door_done  out  1  1-cycle pulse: a door cycle has completed and the door is closed

Behaviour:
- Reset is asynchronous: clk is used for all state; reset acts immediately.
  - On reset: state=CLOSED, move_cnt=0, reopen_cnt=0.
  - Output values: door_closed=1; door_open, motor_open, motor_close, nudge and door_done all 0.
  - Reset mid-stroke aborts the stroke with no door_done.
- All outputs are registered, decoded from the next state, so each output changes in the same cycle as the state.
- move_cnt width is clog2(2*MOVE_CYCLES). reopen_cnt width is clog2(MAX_REOPEN+1), with a minimum of 1.
- CLOSED state:
  - Outputs: door_closed=1, all other outputs 0.
  - Transition: if (open_req or open_btn) and !car_moving, go to OPENING with move_cnt=0 and reopen_cnt=0.
  - If car_moving=1, requests are dropped, not queued.
  - car_moving has no effect in any other state.
- OPENING state:
  - Outputs: motor_open=1.
  - move_cnt increments every cycle.
  - At move_cnt==MOVE_CYCLES-1, go to OPEN. OPENING therefore lasts exactly MOVE_CYCLES cycles.
  - All inputs except reset are ignored during OPENING.
- OPEN state:
  - Outputs: door_open=1.
  - Priority order at each edge:
    1. open_btn=1: stay in OPEN and drive door_open=0 for the following cycle, which restarts the dwell timer.
    2. timer_T=1 or close_btn=1: go to CLOSING with move_cnt=0.
    3. Otherwise stay in OPEN.
  - When open_btn and timer_T are high in the same cycle, open_btn wins.
- CLOSING state:
  - Outputs: motor_close=1.
  - move_cnt increments every cycle.
  - If obstruct or open_btn is high at an edge:
    - If reopen_cnt<MAX_REOPEN: reopen_cnt++, go to OPENING with move_cnt=0.
    - Otherwise: go to NUDGE with move_cnt=0.
  - Obstruction on the final cycle (move_cnt==MOVE_CYCLES-1) still reverses.
  - Otherwise, at move_cnt==MOVE_CYCLES-1, go to CLOSED and assert door_done for the first CLOSED cycle only.
  - close_btn is ignored in CLOSING.
- NUDGE state:
  - Outputs: motor_close=1, nudge=1.
  - Lasts 2*MOVE_CYCLES cycles.
  - obstruct, open_btn and close_btn are all ignored.
  - On completion, go to CLOSED with a door_done pulse.
- MAX_REOPEN=0 means the first obstruction goes straight to NUDGE.
- Unused state encodings recover to CLOSED on the next clock.

Test Plan:
All scenarios use MOVE_CYCLES=4, MAX_REOPEN=2, and a bench-driven timer_T.
- Reset released with inputs idle -> door_closed=1, all other outputs 0. Assert reset for 1 cycle mid-OPENING -> outputs return to reset values immediately; no door_done.
- open_req pulse at edge k:
  - motor_open=1 for 4 cycles.
  - door_open=1 from edge k+4.
  - timer_T pulse -> motor_close=1 for 4 cycles.
  - Then door_closed=1 with door_done=1 for exactly 1 cycle.
- car_moving=1 with open_req and open_btn pulsed -> stays CLOSED, motor_open never asserts. Deassert car_moving, then press open_btn -> opening starts.
- In OPEN, open_btn and timer_T high in the same cycle -> stays OPEN, door_open=0 for exactly 1 cycle, then 1 again. close_btn alone -> CLOSING on the next cycle.
- Obstruct during CLOSING 3 times:
  - First two obstructions -> OPENING with a full 4-cycle reopen each.
  - Third obstruction -> nudge=1 and motor_close=1 for 8 cycles, with obstruct held high throughout.
  - Then door_done pulse, and nudge=0.
- Obstruct asserted on the final CLOSING cycle (move_cnt=3) -> OPENING; no door_done and no door_closed glitch.
